// File: rtl/pipe_if_pkg.sv
// rtl/pipe_if_pkg.sv - shared fetch/decode encodings, NOP value and reset PC
package pipe_if_pkg;

    localparam logic [1:0]  PCSRC_SEQ        = 2'b00;
    localparam logic [1:0]  PCSRC_BR         = 2'b01;
    localparam logic [1:0]  PCSRC_JR         = 2'b10;
    localparam logic [1:0]  PCSRC_J          = 2'b11;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_FULL  = 1'b1
    } if_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pipe_if_skid.sv
// rtl/pipe_if_skid.sv - one-entry skid buffer holding a fetched {inst, pc+4} pair
module pipe_if_skid (
    input  logic        clock,
    input  logic        resetn,
    input  logic        load,
    input  logic        unload,
    input  logic [63:0] din,
    output logic        full,
    output logic [63:0] dout
);

    logic        r_full;
    logic [63:0] r_data;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (load) begin
            r_full <= 1'b1;
            r_data <= din;
        end else if (unload) begin
            r_full <= 1'b0;
        end
    end

    assign full = r_full;
    assign dout = r_data;

endmodule

// File: rtl/pipe_if_stage.sv
// rtl/pipe_if_stage.sv - instruction fetch stage with load-use stall, skid buffer and delayed-branch redirect
module pipe_if_stage
    import pipe_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        wpcir,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] da,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] dinst,
    output logic [31:0] dpc4,
    output logic        dvalid
);

    if_state_t   r_state, w_state_next;
    logic [31:0] r_pc, r_dinst, r_dpc4, r_pend;
    logic        r_dvalid, r_pend_v;

    logic        w_xfer, w_redir, w_skid_full;
    logic [31:0] w_pc4, w_target, w_seq_next, w_pc_next;
    logic [63:0] w_buf_dout;
    logic        w_load, w_unload, w_d_from_mem, w_d_from_buf, w_d_bubble;
    logic        w_pc_load, w_pend_set, w_pend_clr;

    assign imem_req  = (r_state == ST_FETCH);
    assign imem_addr = r_pc;
    assign w_xfer    = imem_req & imem_ready;
    assign w_pc4     = r_pc + 32'd4;

    // Only a real instruction leaving D may redirect; a stalled or bubbled D cannot.
    assign w_redir = r_dvalid & wpcir & (pcsource != PCSRC_SEQ);

    always_comb begin
        w_target = jpc;
        case (pcsource)
            PCSRC_BR: w_target = bpc;
            PCSRC_JR: w_target = da;
            default:  w_target = jpc;
        endcase
        w_target = word_align(w_target);
    end

    assign w_seq_next = w_redir  ? w_target :
                        r_pend_v ? r_pend   : w_pc4;

    always_ff @(posedge clock) begin
        if (!resetn) r_state <= ST_FETCH;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_unload     = 1'b0;
        w_d_from_mem = 1'b0;
        w_d_from_buf = 1'b0;
        w_d_bubble   = 1'b0;
        w_pc_load    = 1'b0;
        w_pc_next    = r_pc;
        w_pend_set   = 1'b0;
        w_pend_clr   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (w_xfer) begin
                    w_pc_load  = 1'b1;
                    w_pc_next  = w_seq_next;
                    w_pend_clr = 1'b1;
                    if (wpcir) begin
                        w_d_from_mem = 1'b1;
                    end else begin
                        w_load       = 1'b1;
                        w_state_next = ST_FULL;
                    end
                end else if (wpcir) begin
                    // Delay slot not yet fetched: remember the target for the next transfer.
                    w_d_bubble = 1'b1;
                    w_pend_set = w_redir;
                end
            end
            ST_FULL: begin
                if (wpcir && w_skid_full) begin
                    w_unload     = 1'b1;
                    w_d_from_buf = 1'b1;
                    w_state_next = ST_FETCH;
                    if (w_redir) begin
                        w_pc_load = 1'b1;
                        w_pc_next = w_target;
                    end
                end
            end
            default: w_state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_pc     <= RESET_PC;
            r_dinst  <= NOP_INST;
            r_dpc4   <= '0;
            r_dvalid <= 1'b0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
        end else begin
            if (w_pc_load) r_pc <= w_pc_next;
            if (w_d_from_mem) begin
                r_dinst  <= imem_rdata;
                r_dpc4   <= w_pc4;
                r_dvalid <= 1'b1;
            end else if (w_d_from_buf) begin
                r_dinst  <= w_buf_dout[63:32];
                r_dpc4   <= w_buf_dout[31:0];
                r_dvalid <= 1'b1;
            end else if (w_d_bubble) begin
                r_dinst  <= NOP_INST;
                r_dvalid <= 1'b0;
            end
            if (w_pend_clr) begin
                r_pend_v <= 1'b0;
            end else if (w_pend_set) begin
                r_pend_v <= 1'b1;
                r_pend   <= w_target;
            end
        end
    end

    pipe_if_skid u_skid (
        .clock  (clock),
        .resetn (resetn),
        .load   (w_load),
        .unload (w_unload),
        .din    ({imem_rdata, w_pc4}),
        .full   (w_skid_full),
        .dout   (w_buf_dout)
    );

    assign pc     = r_pc;
    assign dinst  = r_dinst;
    assign dpc4   = r_dpc4;
    assign dvalid = r_dvalid;

endmodule

// File: tb/tb_pipe_if_stage.sv
// tb/tb_pipe_if_stage.sv - directed and randomized check of pipe_if_stage against a queue-based fetch model
module tb_pipe_if_stage;
    import pipe_if_pkg::*;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        wpcir = 1'b1;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = '0, da = '0, jpc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] pc, dinst, dpc4;
    logic        dvalid;
    logic [31:0] mem_key = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    assign imem_rdata = imem_addr ^ mem_key;

    pipe_if_stage dut (
        .clock      (clock),
        .resetn     (resetn),
        .wpcir      (wpcir),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .da         (da),
        .jpc        (jpc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .dinst      (dinst),
        .dpc4       (dpc4),
        .dvalid     (dvalid)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } fetch_t;

    fetch_t      m_park[$];
    logic [31:0] m_pc = '0, m_dinst = '0, m_dpc4 = '0, m_pend = '0;
    logic        m_dvalid = 1'b0, m_pend_v = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic        accept;
        logic [31:0] dest;
        fetch_t      f;
        accept = m_dvalid && wpcir && (pcsource != 2'b00);
        if (pcsource == 2'b01)      dest = bpc;
        else if (pcsource == 2'b10) dest = da;
        else                        dest = jpc;
        dest = dest & 32'hFFFF_FFFC;
        if (!resetn) begin
            m_park.delete();
            m_pc = RESET_PC_DEFAULT; m_dinst = '0; m_dpc4 = '0; m_dvalid = 1'b0; m_pend_v = 1'b0;
        end else if (m_park.size() != 0) begin
            if (wpcir) begin
                f = m_park.pop_front();
                m_dinst = f.inst; m_dpc4 = f.pc4; m_dvalid = 1'b1;
                if (accept) m_pc = dest;
            end
        end else if (imem_ready) begin
            f.inst = m_pc ^ mem_key;
            f.pc4  = m_pc + 32'd4;
            if (accept)        m_pc = dest;
            else if (m_pend_v) begin m_pc = m_pend; m_pend_v = 1'b0; end
            else               m_pc = f.pc4;
            if (wpcir) begin m_dinst = f.inst; m_dpc4 = f.pc4; m_dvalid = 1'b1; end
            else       m_park.push_back(f);
        end else if (wpcir) begin
            if (accept) begin m_pend = dest; m_pend_v = 1'b1; end
            m_dinst = '0; m_dvalid = 1'b0;
        end
    endtask

    task automatic step(input logic rn, input logic rdy, input logic wp, input logic [1:0] ps);
        resetn = rn; imem_ready = rdy; wpcir = wp; pcsource = ps;
        model_edge();
        @(posedge clock);
        #1;
        check_eq("imem_req",  {31'b0, imem_req}, {31'b0, (m_park.size() == 0)});
        check_eq("imem_addr", imem_addr, m_pc);
        check_eq("pc",        pc, m_pc);
        check_eq("dinst",     dinst, m_dinst);
        check_eq("dpc4",      dpc4, m_dpc4);
        check_eq("dvalid",    {31'b0, dvalid}, {31'b0, m_dvalid});
    endtask

    task automatic reset_then_fetch(input int n);
        step(1'b0, 1'b1, 1'b1, 2'b00);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1, 2'b00);
    endtask

    initial begin
        // straight-line fetch after reset
        step(1'b0, 1'b1, 1'b1, 2'b00);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_dvalid", {31'b0, dvalid}, 32'h0);
        check_eq("rst_req", {31'b0, imem_req}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b1, 2'b00);
            check_eq("s1_dinst", dinst, 32'(4 * k));
            check_eq("s1_dvalid", {31'b0, dvalid}, 32'h1);
        end

        // park a fetch at 0x10 under a 3-cycle stall
        step(1'b1, 1'b1, 1'b1, 2'b00);
        check_eq("s2_pc_pre", pc, 32'h10);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 2'b00);
        check_eq("s2_req", {31'b0, imem_req}, 32'h0);
        check_eq("s2_pc", pc, 32'h14);
        step(1'b1, 1'b1, 1'b1, 2'b00);
        check_eq("s2_dinst", dinst, 32'h10);
        check_eq("s2_req_back", {31'b0, imem_req}, 32'h1);
        step(1'b1, 1'b1, 1'b1, 2'b00);
        check_eq("s2_resume", dinst, 32'h14);

        // taken branch at 0x20, memory ready
        bpc = 32'h100; da = 32'h300; jpc = 32'h500;
        reset_then_fetch(9);
        check_eq("s3_dinst_br", dinst, 32'h20);
        step(1'b1, 1'b1, 1'b1, 2'b01);
        check_eq("s3_slot", dinst, 32'h24);
        check_eq("s3_pc", pc, 32'h100);
        step(1'b1, 1'b1, 1'b1, 2'b00);
        check_eq("s3_target", dinst, 32'h100);

        // same branch with the delay slot fetch stalled 4 cycles
        reset_then_fetch(9);
        step(1'b1, 1'b0, 1'b1, 2'b01);
        check_eq("s4_bubble", {31'b0, dvalid}, 32'h0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 2'b00);
        check_eq("s4_pc_wait", pc, 32'h24);
        step(1'b1, 1'b1, 1'b1, 2'b00);
        check_eq("s4_slot", dinst, 32'h24);
        check_eq("s4_pc", pc, 32'h100);
        step(1'b1, 1'b1, 1'b1, 2'b00);
        check_eq("s4_target", dinst, 32'h100);

        // ignored redirects: D empty, then D stalled
        da = 32'h200;
        step(1'b0, 1'b1, 1'b1, 2'b00);
        step(1'b1, 1'b1, 1'b1, 2'b10);
        check_eq("s5_novalid", pc, 32'h4);
        step(1'b1, 1'b1, 1'b0, 2'b10);
        check_eq("s5_nowp", pc, 32'h8);
        step(1'b1, 1'b1, 1'b1, 2'b00);
        step(1'b1, 1'b1, 1'b1, 2'b00);
        check_eq("s5_seq", pc, 32'hC);

        // PC wrap, then reset while FULL
        mem_key = 32'h1234_0000;
        jpc = 32'hFFFF_FFFF;
        reset_then_fetch(1);
        step(1'b1, 1'b1, 1'b1, 2'b11);
        check_eq("s6_jump", pc, 32'hFFFF_FFFC);
        step(1'b1, 1'b1, 1'b1, 2'b00);
        check_eq("s6_wrap_pc", pc, 32'h0);
        check_eq("s6_wrap_dpc4", dpc4, 32'h0);
        step(1'b1, 1'b1, 1'b0, 2'b00);
        check_eq("s6_full", {31'b0, imem_req}, 32'h0);
        step(1'b0, 1'b1, 1'b1, 2'b00);
        check_eq("s6_rst_pc", pc, 32'h0);
        check_eq("s6_rst_dvalid", {31'b0, dvalid}, 32'h0);
        check_eq("s6_rst_req", {31'b0, imem_req}, 32'h1);
        step(1'b1, 1'b1, 1'b1, 2'b00);
        check_eq("s6_after_pc", pc, 32'h4);

        // randomized traffic
        mem_key = 32'hC3A5_0000;
        for (int c = 0; c < 3000; c++) begin
            logic       rn, rdy, wp;
            logic [1:0] ps;
            rn  = ($urandom_range(0, 99) != 0);
            rdy = ($urandom_range(0, 99) < 70);
            wp  = ($urandom_range(0, 99) < 80);
            ps  = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
            bpc = $urandom();
            da  = $urandom();
            jpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom();
            step(rn, rdy, wp, ps);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_if_stage.md
PIPE_IF_STAGE -- requirements
Module: pipe_if_stage

Interface
REQ-001 SHALL have a single clock and a reset that is synchronous and active-low.
REQ-002 SHALL expose the following ports:
- clock  in  1  rising-edge clock
- resetn  in  1  synchronous active-low reset
- wpcir  in  1  0 = hold the F/D boundary (load-use stall from decode control)
- pcsource  in  2  next-PC select from decode: 00 seq, 01 branch, 10 jr, 11 j/jal
- bpc  in  32  branch target
- da  in  32  jr register value
- jpc  in  32  jump target
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (= pc)
- imem_ready  in  1  fetch transfer completes this cycle (req & ready)
- imem_rdata  in  32  instruction, valid when imem_ready
- pc  out  32  current fetch PC
- dinst  out  32  D-stage instruction register
- dpc4  out  32  D-stage PC+4 register
- dvalid  out  1  D-stage holds a real instruction (0 = bubble)
REQ-003 SHALL have a parameter RESET_PC, default 32'h0000_0000, which is the PC value loaded at reset.

Function
REQ-004 SHALL implement FSM states FETCH (imem_req=1) and FULL (imem_req=0, one instruction parked in skid buffer).
REQ-005 imem_addr SHALL equal pc, and pc SHALL change only on a transfer or in FULL; addr stable while req & !ready.
REQ-006 FETCH, transfer, wpcir=1: dinst<=imem_rdata, dpc4<=pc+4, dvalid<=1, pc<=next PC, stay FETCH.
REQ-007 FETCH, transfer, wpcir=0: buffer<=(imem_rdata, pc+4), pc<=next PC, D held, go FULL.
REQ-008 FETCH, no transfer: wpcir=1 -> dinst<=0 (NOP), dvalid<=0; wpcir=0 -> D held.
REQ-009 FULL, wpcir=1: D<=buffer, dvalid<=1, go FETCH; wpcir=0: hold everything.
REQ-010 Redirect SHALL be accepted only when dvalid=1, wpcir=1, pcsource!=00; target = bpc/da/jpc for 01/10/11, low 2 bits forced to 00.
REQ-011 Delayed branch, one slot: the redirect applies to the fetch after the instruction currently in F or in the buffer.
REQ-012 Redirect accepted in FETCH with transfer: pc<=target. In FETCH without transfer: pending<=target, pend_v<=1. In FULL: pc<=target.
REQ-013 Next PC on transfer SHALL have the priority: accepted redirect > pending target (clears pend_v) > pc+4.
REQ-014 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-015 Fetch latency SHALL be 1 cycle: an instruction transferred at edge N is visible on dinst after edge N when wpcir=1.

Reset
REQ-016 When resetn=0 at an edge: pc=RESET_PC, dinst=0, dpc4=0, dvalid=0, pend_v=0, buffer cleared, state FETCH.
REQ-017 A transfer or redirect that coincides with resetn=0 SHALL be discarded; reset mid-wait or mid-FULL behaves identically.
REQ-018 imem_req SHALL be 1 in the first cycle after reset is released.

Structure
REQ-019 The pcsource encodings, NOP value (32'h0) and default RESET_PC SHALL live in a shared include used by decode control and this block.
REQ-020 The one-entry skid buffer SHALL be a sub-module, pipe_if_skid (load, unload, full flag, 64-bit payload).

Verification
REQ-021 Verification SHALL cover the following scenarios:
- Reset, ready always 1, wpcir=1, rdata=pc: dinst sequence 0,4,8 on cycles 1,2,3; dvalid=1 from cycle 1.
- Ready=1, wpcir=0 for 3 cycles at pc=0x10: one fetch parked, imem_req=0, pc=0x14; on wpcir=1, dinst=mem[0x10], then fetching resumes at 0x14.
- Branch in D at 0x20, pcsource=01, bpc=0x100, ready=1: D receives 0x24 (delay slot), then 0x100.
- Same branch with ready=0 for 4 cycles: pend_v=1, dvalid=0 bubbles; after the delay slot arrives, pc=0x100.
- Redirect with dvalid=0 or wpcir=0 (pcsource=10, da=0x200): ignored, pc continues sequentially.
- pc=0xFFFFFFFC fetch -> pc wraps to 0; resetn=0 during FULL -> pc=RESET_PC, dvalid=0, buffer empty.
